// File: rtl/axi_stream_remove_header.sv
// Strips a 1..DATA_BYTE_WD byte header from the front of an AXI-Stream packet onto a
// side channel and re-aligns the remaining payload to the MSB lane of beat 0.
module axi_stream_remove_header #(
   parameter int DATA_WD      = 32,
   parameter int DATA_BYTE_WD = DATA_WD / 8,
   parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    valid_cfg,
   output logic                    ready_cfg,
   input  logic [BYTE_CNT_WD-1:0]  byte_remove_cnt,
   input  logic                    valid_in,
   output logic                    ready_in,
   input  logic [DATA_WD-1:0]      data_in,
   input  logic [DATA_BYTE_WD-1:0] keep_in,
   input  logic                    last_in,
   output logic                    valid_out,
   input  logic                    ready_out,
   output logic [DATA_WD-1:0]      data_out,
   output logic [DATA_BYTE_WD-1:0] keep_out,
   output logic                    last_out,
   output logic                    valid_hdr,
   input  logic                    ready_hdr,
   output logic [DATA_WD-1:0]      data_hdr,
   output logic [DATA_BYTE_WD-1:0] keep_hdr
);

   // Counts must hold R+n, which can reach 2*DATA_BYTE_WD.
   localparam int CNT_W = BYTE_CNT_WD + 2;
   localparam logic [CNT_W-1:0] BYTES_C = CNT_W'(DATA_BYTE_WD);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_HDR   = 2'd1;
   localparam logic [1:0] S_BODY  = 2'd2;
   localparam logic [1:0] S_FLUSH = 2'd3;

   function automatic logic [CNT_W-1:0] f_popcnt(input logic [DATA_BYTE_WD-1:0] k);
      logic [CNT_W-1:0] c;
      c = '0;
      for (int i = 0; i < DATA_BYTE_WD; i++) c = c + CNT_W'(k[i]);
      return c;
   endfunction

   function automatic logic [DATA_WD-1:0] f_byte_mask(input logic [DATA_BYTE_WD-1:0] k);
      logic [DATA_WD-1:0] m;
      for (int i = 0; i < DATA_BYTE_WD; i++) m[8*i +: 8] = {8{k[i]}};
      return m;
   endfunction

   function automatic logic [DATA_BYTE_WD-1:0] f_keep_msb(input logic [CNT_W-1:0] n);
      return ~({DATA_BYTE_WD{1'b1}} >> n);
   endfunction

   logic [1:0]              r_state;
   logic [CNT_W-1:0]        r_hdr_len;
   logic [DATA_WD-1:0]      r_res;
   logic [DATA_BYTE_WD-1:0] r_res_keep;

   logic [CNT_W-1:0]        w_r;
   logic [CNT_W-1:0]        w_n;
   logic                    w_more;
   logic [DATA_WD-1:0]      w_data;
   logic [DATA_WD-1:0]      w_top;
   logic [DATA_WD-1:0]      w_low;
   logic                    w_out_free;
   logic                    w_hdr_free;
   logic                    w_in_hs;
   logic                    w_cfg_hs;

   // Invalid lanes are zeroed so they never leak into the residue or header.
   assign w_data     = data_in & f_byte_mask(keep_in);
   assign w_r        = BYTES_C - r_hdr_len;
   assign w_n        = f_popcnt(keep_in);
   assign w_more     = (w_n > r_hdr_len);
   assign w_top      = w_data >> (8 * w_r);
   assign w_low      = w_data << (8 * r_hdr_len);
   assign w_out_free = !valid_out || ready_out;
   assign w_hdr_free = !valid_hdr || ready_hdr;

   assign ready_cfg = rst_n && (r_state == S_IDLE);
   assign ready_in  = rst_n && (((r_state == S_BODY) && w_out_free) ||
                                ((r_state == S_HDR) && w_out_free && w_hdr_free));
   assign w_in_hs   = valid_in && ready_in;
   assign w_cfg_hs  = valid_cfg && ready_cfg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_hdr_len  <= '0;
         r_res      <= '0;
         r_res_keep <= '0;
         valid_out  <= 1'b0;
         data_out   <= '0;
         keep_out   <= '0;
         last_out   <= 1'b0;
         valid_hdr  <= 1'b0;
         data_hdr   <= '0;
         keep_hdr   <= '0;
      end else begin
         if (valid_out && ready_out) valid_out <= 1'b0;
         if (valid_hdr && ready_hdr) valid_hdr <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_cfg_hs) begin
                  r_hdr_len <= CNT_W'(byte_remove_cnt) + CNT_W'(1);
                  r_state   <= S_HDR;
               end
            end
            S_HDR: begin
               if (w_in_hs) begin
                  valid_hdr  <= 1'b1;
                  data_hdr   <= w_top;
                  // Short out-of-contract beats leave keep_hdr covering only the bytes present.
                  keep_hdr   <= keep_in >> w_r;
                  r_res      <= w_low;
                  r_res_keep <= f_keep_msb(w_n - r_hdr_len);
                  if (!last_in)    r_state <= S_BODY;
                  else if (w_more) r_state <= S_FLUSH;
                  else             r_state <= S_IDLE;
               end
            end
            S_BODY: begin
               if (w_in_hs) begin
                  valid_out  <= 1'b1;
                  data_out   <= r_res | w_top;
                  r_res      <= w_low;
                  r_res_keep <= f_keep_msb(w_n - r_hdr_len);
                  if (!last_in || w_more) begin
                     keep_out <= {DATA_BYTE_WD{1'b1}};
                     last_out <= 1'b0;
                     r_state  <= last_in ? S_FLUSH : S_BODY;
                  end else begin
                     keep_out <= f_keep_msb(w_r + w_n);
                     last_out <= 1'b1;
                     r_state  <= S_IDLE;
                  end
               end
            end
            S_FLUSH: begin
               if (w_out_free) begin
                  valid_out <= 1'b1;
                  data_out  <= r_res;
                  keep_out  <= r_res_keep;
                  last_out  <= 1'b1;
                  r_state   <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_stream_remove_header.sv
// Scoreboard bench for axi_stream_remove_header: directed packets push expected
// header/payload beats, independent monitors pop and compare on each handshake.
module tb_axi_stream_remove_header;

   typedef struct packed {
      logic [31:0] d;
      logic [3:0]  k;
      logic        l;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        valid_cfg = 1'b0;
   logic        ready_cfg;
   logic [1:0]  byte_remove_cnt = '0;
   logic        valid_in = 1'b0;
   logic        ready_in;
   logic [31:0] data_in = '0;
   logic [3:0]  keep_in = '0;
   logic        last_in = 1'b0;
   logic        valid_out;
   logic        ready_out = 1'b1;
   logic [31:0] data_out;
   logic [3:0]  keep_out;
   logic        last_out;
   logic        valid_hdr;
   logic        ready_hdr = 1'b1;
   logic [31:0] data_hdr;
   logic [3:0]  keep_hdr;

   int checks = 0;
   int errors = 0;
   int vout_cycles = 0;
   int v0 = 0;
   beat_t exp_out[$];
   beat_t exp_hdr[$];

   logic  po_blk = 1'b0, ph_blk = 1'b0;
   beat_t po_val, ph_val, e;

   always #5 clk = ~clk;

   axi_stream_remove_header #(.DATA_WD(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .valid_cfg(valid_cfg), .ready_cfg(ready_cfg), .byte_remove_cnt(byte_remove_cnt),
      .valid_in(valid_in), .ready_in(ready_in), .data_in(data_in), .keep_in(keep_in),
      .last_in(last_in),
      .valid_out(valid_out), .ready_out(ready_out), .data_out(data_out),
      .keep_out(keep_out), .last_out(last_out),
      .valid_hdr(valid_hdr), .ready_hdr(ready_hdr), .data_hdr(data_hdr), .keep_hdr(keep_hdr)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitors: compare on handshake, verify holds while blocked.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            po_blk = 1'b0;
            ph_blk = 1'b0;
         end else begin
            if (valid_out) vout_cycles++;
            if (po_blk) chk("out_hold", {valid_out, data_out, keep_out, last_out}, {1'b1, po_val});
            if (ph_blk) chk("hdr_hold", {valid_hdr, data_hdr, keep_hdr}, {1'b1, ph_val.d, ph_val.k});
            if (valid_out && !ready_out) chk("rdy_in_blocked", 64'(ready_in), 64'd0);
            if (valid_out && ready_out) begin
               if (exp_out.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL payload_unexpected: got %h expected none", data_out);
               end else begin
                  e = exp_out.pop_front();
                  chk("payload", 64'({data_out, keep_out, last_out}), 64'(e));
               end
            end
            if (valid_hdr && ready_hdr) begin
               if (exp_hdr.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL hdr_unexpected: got %h expected none", data_hdr);
               end else begin
                  e = exp_hdr.pop_front();
                  chk("header", 64'({data_hdr, keep_hdr}), 64'({e.d, e.k}));
               end
            end
            po_blk = valid_out && !ready_out;
            po_val = '{data_out, keep_out, last_out};
            ph_blk = valid_hdr && !ready_hdr;
            ph_val = '{data_hdr, keep_hdr, 1'b0};
         end
      end
   end

   task automatic send_cfg(input logic [1:0] c);
      int n;
      valid_cfg = 1'b1;
      byte_remove_cnt = c;
      for (n = 0; n < 200; n++) begin
         @(negedge clk);
         if (ready_cfg) break;
      end
      if (n == 200) begin
         checks++; errors++;
         $display("FAIL cfg_timeout: got no ready_cfg expected ready_cfg=1");
      end
      @(posedge clk); #1;
      valid_cfg = 1'b0;
   endtask

   task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
      int n;
      valid_in = 1'b1;
      data_in = d;
      keep_in = k;
      last_in = l;
      for (n = 0; n < 200; n++) begin
         @(negedge clk);
         if (ready_in) break;
      end
      if (n == 200) begin
         checks++; errors++;
         $display("FAIL beat_timeout: got no ready_in expected ready_in=1 for %h", d);
      end
      @(posedge clk); #1;
      valid_in = 1'b0;
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 100; i++) begin
         if (exp_out.size() == 0 && exp_hdr.size() == 0) break;
         @(negedge clk);
      end
      repeat (3) @(posedge clk);
      #1;
      chk({name, "_left"}, 64'({exp_out.size(), exp_hdr.size()}), 64'd0);
      @(negedge clk);
      chk({name, "_idle"}, 64'(ready_cfg), 64'd1);
      @(posedge clk); #1;
   endtask

   task automatic reset_check();
      @(posedge clk);
      repeat (3) begin
         @(negedge clk);
         chk("rst_ctrl", 64'({ready_cfg, ready_in, valid_out, valid_hdr, last_out, keep_out, keep_hdr}), 64'd0);
         chk("rst_data_out", 64'(data_out), 64'd0);
         chk("rst_data_hdr", 64'(data_hdr), 64'd0);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("cfg_after_rst", 64'(ready_cfg), 64'd1);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      reset_check();

      // Scenario 1: hdr_len 2, body ends exactly on residue
      exp_hdr.push_back('{32'h0000AABB, 4'h3, 1'b0});
      exp_out.push_back('{32'h01020304, 4'hF, 1'b0});
      exp_out.push_back('{32'h05060708, 4'hF, 1'b1});
      send_cfg(2'd1);
      send_beat(32'hAABB0102, 4'hF, 1'b0);
      send_beat(32'h03040506, 4'hF, 1'b0);
      send_beat(32'h07080000, 4'hC, 1'b1);
      drain("s1");

      // Scenario 2: hdr_len 1, last beat spills into FLUSH
      exp_hdr.push_back('{32'h00000011, 4'h1, 1'b0});
      exp_out.push_back('{32'h22334455, 4'hF, 1'b0});
      exp_out.push_back('{32'h66770000, 4'hC, 1'b1});
      send_cfg(2'd0);
      send_beat(32'h11223344, 4'hF, 1'b0);
      send_beat(32'h55667788, 4'hE, 1'b1);
      drain("s2");

      // Scenario 3: full-beat header, pass-through body
      exp_hdr.push_back('{32'hDEADBEEF, 4'hF, 1'b0});
      exp_out.push_back('{32'h12345678, 4'hF, 1'b1});
      send_cfg(2'd3);
      send_beat(32'hDEADBEEF, 4'hF, 1'b0);
      send_beat(32'h12345678, 4'hF, 1'b1);
      drain("s3");

      // Scenario 4: header-only packet, no payload
      v0 = vout_cycles;
      exp_hdr.push_back('{32'hCAFEF00D, 4'hF, 1'b0});
      send_cfg(2'd3);
      send_beat(32'hCAFEF00D, 4'hF, 1'b1);
      drain("s4");
      chk("s4_no_payload", 64'(vout_cycles - v0), 64'd0);

      // Scenario 5: scenario 1 under back-pressure on both outputs
      exp_hdr.push_back('{32'h0000AABB, 4'h3, 1'b0});
      exp_out.push_back('{32'h01020304, 4'hF, 1'b0});
      exp_out.push_back('{32'h05060708, 4'hF, 1'b1});
      fork
         begin
            send_cfg(2'd1);
            send_beat(32'hAABB0102, 4'hF, 1'b0);
            send_beat(32'h03040506, 4'hF, 1'b0);
            send_beat(32'h07080000, 4'hC, 1'b1);
         end
         begin
            ready_hdr = 1'b0;
            repeat (5) @(posedge clk);
            #1 ready_hdr = 1'b1;
         end
         begin
            repeat (3) @(posedge clk);
            #1 ready_out = 1'b0;
            repeat (3) @(posedge clk);
            #1 ready_out = 1'b1;
         end
      join
      drain("s5");

      // Scenario 6: reset mid-packet, then scenario 2 must be clean
      exp_hdr.push_back('{32'h0000AABB, 4'h3, 1'b0});
      send_cfg(2'd1);
      send_beat(32'hAABB0102, 4'hF, 1'b0);
      send_beat(32'h03040506, 4'hF, 1'b0);
      rst_n = 1'b0;
      exp_out.delete();
      reset_check();
      chk("s6_hdr_taken", 64'(exp_hdr.size()), 64'd0);
      exp_hdr.delete();
      exp_hdr.push_back('{32'h00000011, 4'h1, 1'b0});
      exp_out.push_back('{32'h22334455, 4'hF, 1'b0});
      exp_out.push_back('{32'h66770000, 4'hC, 1'b1});
      send_cfg(2'd0);
      send_beat(32'h11223344, 4'hF, 1'b0);
      send_beat(32'h55667788, 4'hE, 1'b1);
      drain("s6");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
